idli_sqi_resp_m: RTL
====================

// Module: idli_sqi_resp_m
// PURPOSE
//  Synthesisable SQI (quad-SPI) memory responder: the device end of the core's
//  memory port (sck/cs/sio). Decodes command, address and dummy nibbles, then
//  serves byte reads and writes from an internal byte array. Used as an on-chip
//  boot/scratch RAM model and as the bench target for the core's SQI initiator.
// PARAMETERS
//  DEPTH   256            bytes of storage; power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  derived; only the low ADDR_W address bits are used
// PORTS
//  i_resp_gck      in   1  clock (single clock domain shared with the core)
//  i_resp_rst_n    in   1  reset, asynchronous, active-low
//  i_resp_sck      in   1  SQI clock from initiator, synchronous to i_resp_gck
//  i_resp_cs       in   1  chip select, active-low
//  i_resp_sio      in   4  nibble from initiator
//  o_resp_sio      out  4  nibble to initiator
//  o_resp_io_mode  out  1  sqi_io_mode_t: IN = responder not driving, OUT = driving
// BEHAVIOUR
//  - Reset: o_resp_sio=4'h0, o_resp_io_mode=IN, state IDLE, sck_q=0, counters 0.
//    Memory array is NOT reset.
//  - Edges: sck_q registers i_resp_sck; rise = sck & ~sck_q, fall = ~sck & sck_q.
//    Initiator holds each sck level >= 1 gck cycle. Edges ignored while cs high.
//  - Nibbles sampled on rise, MSB nibble first. Output updated on the gck cycle
//    of fall, visible the next cycle, stable until the next fall.
//  - FSM: IDLE -> CMD (cs low) -> after 2 nibbles: 8'h03 READ or 8'h02 WRITE
//    -> ADDR (6 nibbles, 24b, upper bits dropped); any other cmd -> IGNORE.
//    READ: ADDR -> DUMMY (2 nibbles) -> RDATA. WRITE: ADDR -> WDATA.
//    RDATA/WDATA/IGNORE persist until cs high.
//  - cs high in any state: next gck cycle -> IDLE, io_mode=IN, o_sio=0,
//    counters cleared; partial command/address discarded.
//  - RDATA: io_mode=OUT from the fall after the last dummy nibble. Each fall
//    drives mem[addr][7:4] then mem[addr][3:0]; addr increments after the low
//    nibble. io_mode=IN in every other state.
//  - WDATA: high nibble held; byte written on the rise carrying the low nibble,
//    then addr increments. Partial byte at cs rise is discarded.
//  - Wrap: addr increments modulo DEPTH (DEPTH-1 -> 0), reads and writes alike.
//  - rise and cs release in the same cycle: cs wins; nibble dropped.
//  - Async reset mid-transfer: outputs to reset values at once; stored bytes
//    kept, except a write in the same cycle as reset is dropped.
// STRUCTURE
//  - Shared package idli_pkg: sqi_io_mode_t (reused from the core port),
//    SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02, SQI_ADDR_NIBBLES=6,
//    SQI_DUMMY_NIBBLES=2, enum sqi_resp_state_t {IDLE,CMD,ADDR,DUMMY,RDATA,
//    WDATA,IGNORE}.
//  - Sub-module idli_sqi_ram_m: DEPTH x 8 sync-write/async-read byte array
//    (wr_en, wr_addr, wr_data, rd_addr, rd_data). Everything else lives in the
//    top: edge detect, FSM, nibble/addr counters.
// TESTING
//  1 WRITE 02,000010,A5,3C then READ 03,000010,2 dummy -> sio A,5,3,C on
//    successive falls; io_mode OUT only during data.
//  2 DEPTH=256: WRITE at 0000FF bytes 11,22 -> READ 0000FF gives 11,22;
//    READ 000000 gives 22 (wrap).
//  3 cmd FF then 8 nibbles -> io_mode stays IN, o_sio 0, memory unchanged.
//  4 cs high after 3 address nibbles, then full READ 000010 -> A5 (clean restart).
//  5 WRITE 000020: byte 77 then one nibble 9, cs high -> READ gives 77,
//    then previous mem[21] unchanged.
//  6 rst_n low mid-RDATA -> o_sio=0, io_mode=IN immediately; after release
//    READ 000010 -> A5.

Source files
------------

// File: rtl/idli_pkg.sv
// ---------------------------------------------------------------------------
// idli_pkg
//   Shared definitions for the SQI (quad-SPI) memory port.
//   - sqi_io_mode_t     : direction of the sio pins as seen by one end of the
//                         link (IN = not driving, OUT = driving).
//   - SQI_CMD_*         : command bytes understood by the responder.
//   - SQI_*_NIBBLES     : length of the address and dummy phases.
//   - sqi_resp_state_t  : responder protocol states.
// ---------------------------------------------------------------------------
package idli_pkg;

  typedef enum logic {
    SQI_IO_IN  = 1'b0,
    SQI_IO_OUT = 1'b1
  } sqi_io_mode_t;

  localparam logic [7:0]  SQI_CMD_READ      = 8'h03;
  localparam logic [7:0]  SQI_CMD_WRITE     = 8'h02;
  localparam int unsigned SQI_ADDR_NIBBLES  = 6;
  localparam int unsigned SQI_DUMMY_NIBBLES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } sqi_resp_state_t;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_ram_m
//   DEPTH x 8 byte store behind the SQI responder. Writes are synchronous,
//   reads are combinational so the responder can present a nibble on the
//   same cycle it decides to drive. Contents are not reset.
// Ports
//   clk_i      in  1       clock
//   wr_en_i    in  1       write strobe
//   wr_addr_i  in  ADDR_W  write address
//   wr_data_i  in  8       write byte
//   rd_addr_i  in  ADDR_W  read address
//   rd_data_o  out 8       byte at rd_addr_i
// ---------------------------------------------------------------------------
module idli_sqi_ram_m #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/idli_sqi_resp_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_resp_m
//   SQI (quad-SPI) memory responder. Samples command, 24-bit address and
//   dummy nibbles from the initiator, then streams bytes out of (READ 0x03)
//   or into (WRITE 0x02) an internal byte array. Any other command is
//   swallowed until chip select is released.
// Ports
//   i_resp_gck      in  1  system clock; sck is sampled in this domain
//   i_resp_rst_n    in  1  asynchronous active-low reset
//   i_resp_sck      in  1  SQI clock from the initiator
//   i_resp_cs       in  1  chip select, active-low
//   i_resp_sio      in  4  nibble from the initiator (sampled on sck rise)
//   o_resp_sio      out 4  nibble to the initiator (updated on sck fall)
//   o_resp_io_mode  out 1  OUT while the responder drives sio
// ---------------------------------------------------------------------------
module idli_sqi_resp_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic         i_resp_gck,
  input  logic         i_resp_rst_n,
  input  logic         i_resp_sck,
  input  logic         i_resp_cs,
  input  logic [3:0]   i_resp_sio,
  output logic [3:0]   o_resp_sio,
  output sqi_io_mode_t o_resp_io_mode
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(SQI_DUMMY_NIBBLES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            sck_q;
  sqi_resp_state_t state_q;
  logic [2:0]      cnt_q;       // nibble counter within CMD/ADDR/DUMMY
  logic [3:0]      cmd_hi_q;    // first command nibble
  logic            is_read_q;   // command chosen READ (vs WRITE)
  logic [ADDR_W-1:0] addr_q;    // shift target during ADDR, byte pointer after
  logic [3:0]      wr_hi_q;     // high nibble of the byte being written
  logic            nib_lo_q;    // next data nibble is the low half of a byte
  logic [3:0]      sio_q;
  sqi_io_mode_t    io_mode_q;

  logic            sck_rise;
  logic            sck_fall;
  logic [7:0]      cmd_byte;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]      rd_data;
  logic            wr_en;
  logic [7:0]      wr_data;

  // Edges only count while selected; a rise coinciding with cs release is
  // dropped because the cs branch below takes priority as well.
  assign sck_rise = ~i_resp_cs & i_resp_sck & ~sck_q;
  assign sck_fall = ~i_resp_cs & ~i_resp_sck & sck_q;

  assign cmd_byte = {cmd_hi_q, i_resp_sio};
  assign addr_inc = addr_q + ADDR_W'(1);

  // The byte commits on the rise carrying its low nibble. Gating with the
  // reset pin drops a write that lands in the same cycle as reset assertion.
  assign wr_en   = i_resp_rst_n & sck_rise & (state_q == WDATA) & nib_lo_q;
  assign wr_data = {wr_hi_q, i_resp_sio};

  // -------------------------------------------------------------------------
  // Byte store
  // -------------------------------------------------------------------------
  idli_sqi_ram_m #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (i_resp_gck),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data)
  );

  // -------------------------------------------------------------------------
  // Protocol FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_resp_gck or negedge i_resp_rst_n) begin
    if (!i_resp_rst_n) begin
      sck_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_hi_q  <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wr_hi_q   <= '0;
      nib_lo_q  <= 1'b0;
      sio_q     <= '0;
      io_mode_q <= SQI_IO_IN;
    end else begin
      sck_q <= i_resp_sck;

      if (i_resp_cs) begin
        // Deselect aborts whatever was in flight.
        state_q   <= IDLE;
        cnt_q     <= '0;
        addr_q    <= '0;
        nib_lo_q  <= 1'b0;
        sio_q     <= '0;
        io_mode_q <= SQI_IO_IN;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= CMD;
            // A rise on the very first selected cycle is still the first
            // command nibble.
            if (sck_rise) begin
              cmd_hi_q <= i_resp_sio;
              cnt_q    <= 3'd1;
            end
          end

          CMD: begin
            if (sck_rise) begin
              if (cnt_q == 3'd0) begin
                cmd_hi_q <= i_resp_sio;
                cnt_q    <= 3'd1;
              end else begin
                cnt_q <= '0;
                if (cmd_byte == SQI_CMD_READ) begin
                  state_q   <= ADDR;
                  is_read_q <= 1'b1;
                end else if (cmd_byte == SQI_CMD_WRITE) begin
                  state_q   <= ADDR;
                  is_read_q <= 1'b0;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              // Shift MSB-first; bits above ADDR_W fall off the top.
              addr_q <= ADDR_W'({addr_q, i_resp_sio});
              if (cnt_q == ADDR_LAST) begin
                cnt_q    <= '0;
                nib_lo_q <= 1'b0;
                state_q  <= is_read_q ? DUMMY : WDATA;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end

          DUMMY: begin
            if (sck_rise) begin
              if (cnt_q == DUMMY_LAST) begin
                cnt_q   <= '0;
                state_q <= RDATA;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end

          RDATA: begin
            // The fall that ends the last dummy nibble already lands here,
            // so the first data nibble is driven on that fall.
            if (sck_fall) begin
              io_mode_q <= SQI_IO_OUT;
              sio_q     <= nib_lo_q ? rd_data[3:0] : rd_data[7:4];
              nib_lo_q  <= ~nib_lo_q;
              if (nib_lo_q) begin
                addr_q <= addr_inc;
              end
            end
          end

          WDATA: begin
            if (sck_rise) begin
              if (!nib_lo_q) begin
                wr_hi_q  <= i_resp_sio;
                nib_lo_q <= 1'b1;
              end else begin
                nib_lo_q <= 1'b0;
                addr_q   <= addr_inc;
              end
            end
          end

          IGNORE: begin
            // Hold until deselect.
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_resp_sio     = sio_q;
  assign o_resp_io_mode = io_mode_q;

endmodule
